// File: rtl/cpu_datapath_mc.sv
`default_nettype none
// ============================================================================
// Module      : cpu_datapath_mc
// Description : Multicycle CPU core with register file, ALU, branch unit, PC
//               and an internal control FSM on one req/ack memory port.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_datapath_mc #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 13,
  parameter int REG_AW   = 3,
  parameter int IMM_W    = 4,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] pc,
  output logic              retire,
  output logic              beq_taken,
  input  logic [REG_AW-1:0] dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int INSTR_W = 3 + 3*REG_AW + IMM_W;
  localparam int NREGS   = 2**REG_AW;

  localparam logic [ADDR_W-1:0] c_reset_pc = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] c_pc_one   = ADDR_W'(1);
  localparam logic [REG_AW-1:0] c_r0       = '0;

  localparam logic [2:0] c_op_add  = 3'b000;
  localparam logic [2:0] c_op_sub  = 3'b001;
  localparam logic [2:0] c_op_and  = 3'b010;
  localparam logic [2:0] c_op_or   = 3'b011;
  localparam logic [2:0] c_op_addi = 3'b100;
  localparam logic [2:0] c_op_ld   = 3'b101;
  localparam logic [2:0] c_op_st   = 3'b110;
  localparam logic [2:0] c_op_beq  = 3'b111;

  if (DATA_W < INSTR_W) begin : g_bad_data_w
    $error("cpu_datapath_mc: DATA_W must be >= INSTR_W");
  end
  if (ADDR_W <= IMM_W) begin : g_bad_addr_w
    $error("cpu_datapath_mc: ADDR_W must be > IMM_W");
  end

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_pc, w_pc_nxt;
  logic [INSTR_W-1:0]  r_ir, w_ir_nxt;
  logic [DATA_W-1:0]   r_a, w_a_nxt;
  logic [DATA_W-1:0]   r_b, w_b_nxt;
  logic [DATA_W-1:0]   r_d, w_d_nxt;
  logic [DATA_W-1:0]   r_res, w_res_nxt;
  logic                r_mem_req, w_mem_req_nxt;
  logic                r_mem_we, w_mem_we_nxt;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
  logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata_nxt;
  logic                r_retire, w_retire_nxt;
  logic                r_beq_taken, w_beq_taken_nxt;
  logic                w_rf_we;
  logic [DATA_W-1:0]   r_regs [NREGS];

  // Instruction fields, MSB to LSB: op, rd, rs, rt, imm
  logic [2:0]          w_op;
  logic [REG_AW-1:0]   w_rd, w_rs, w_rt;
  logic [IMM_W-1:0]    w_imm;
  logic [DATA_W-1:0]   w_imm_ext;
  logic [ADDR_W-1:0]   w_imm_pc;
  logic [DATA_W-1:0]   w_eff;
  logic [DATA_W-1:0]   w_rd_val, w_rs_val, w_rt_val;

  assign w_op      = r_ir[INSTR_W-1 -: 3];
  assign w_rd      = r_ir[INSTR_W-4 -: REG_AW];
  assign w_rs      = r_ir[INSTR_W-4-REG_AW -: REG_AW];
  assign w_rt      = r_ir[IMM_W+REG_AW-1 -: REG_AW];
  assign w_imm     = r_ir[IMM_W-1:0];
  assign w_imm_ext = {{(DATA_W-IMM_W){w_imm[IMM_W-1]}}, w_imm};
  assign w_imm_pc  = {{(ADDR_W-IMM_W){w_imm[IMM_W-1]}}, w_imm};
  assign w_eff     = r_a + w_imm_ext;

  assign w_rd_val  = (w_rd == c_r0)    ? '0 : r_regs[w_rd];
  assign w_rs_val  = (w_rs == c_r0)    ? '0 : r_regs[w_rs];
  assign w_rt_val  = (w_rt == c_r0)    ? '0 : r_regs[w_rt];
  assign dbg_data  = (dbg_sel == c_r0) ? '0 : r_regs[dbg_sel];

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign pc        = r_pc;
  assign retire    = r_retire;
  assign beq_taken = r_beq_taken;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Fetch requests are issued on the edge that enters FETCH so a zero-wait
  // fetch completes in one cycle; after a store the request waits one cycle
  // to leave an idle gap between accesses.
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_ir_nxt        = r_ir;
    w_a_nxt         = r_a;
    w_b_nxt         = r_b;
    w_d_nxt         = r_d;
    w_res_nxt       = r_res;
    w_mem_req_nxt   = r_mem_req;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_retire_nxt    = 1'b0;
    w_beq_taken_nxt = 1'b0;
    w_rf_we         = 1'b0;

    case (r_state)
      S_FETCH: begin
        if (r_mem_req) begin
          if (mem_ack) begin
            w_ir_nxt      = mem_rdata[INSTR_W-1:0];
            w_pc_nxt      = r_pc + c_pc_one;
            w_mem_req_nxt = 1'b0;
            w_state_nxt   = S_DECODE;
          end
        end else if (run) begin
          w_mem_req_nxt  = 1'b1;
          w_mem_we_nxt   = 1'b0;
          w_mem_addr_nxt = r_pc;
        end
      end

      S_DECODE: begin
        w_a_nxt     = w_rs_val;
        w_b_nxt     = w_rt_val;
        w_d_nxt     = w_rd_val;
        w_state_nxt = S_EXEC;
      end

      S_EXEC: begin
        case (w_op)
          c_op_add:  begin w_res_nxt = r_a + r_b;     w_state_nxt = S_WB; end
          c_op_sub:  begin w_res_nxt = r_a - r_b;     w_state_nxt = S_WB; end
          c_op_and:  begin w_res_nxt = r_a & r_b;     w_state_nxt = S_WB; end
          c_op_or:   begin w_res_nxt = r_a | r_b;     w_state_nxt = S_WB; end
          c_op_addi: begin w_res_nxt = w_eff;         w_state_nxt = S_WB; end
          c_op_ld, c_op_st: begin
            w_mem_req_nxt   = 1'b1;
            w_mem_we_nxt    = (w_op == c_op_st);
            w_mem_addr_nxt  = ADDR_W'(w_eff);
            w_mem_wdata_nxt = r_d;
            w_state_nxt     = S_MEM;
          end
          default: begin
            if (r_d == r_a) begin
              w_pc_nxt        = r_pc + w_imm_pc;
              w_beq_taken_nxt = 1'b1;
            end
            w_retire_nxt   = 1'b1;
            w_mem_req_nxt  = run;
            w_mem_we_nxt   = 1'b0;
            w_mem_addr_nxt = w_pc_nxt;
            w_state_nxt    = S_FETCH;
          end
        endcase
      end

      S_MEM: begin
        if (mem_ack) begin
          w_mem_req_nxt = 1'b0;
          w_mem_we_nxt  = 1'b0;
          if (w_op == c_op_ld) begin
            w_res_nxt   = mem_rdata;
            w_state_nxt = S_WB;
          end else begin
            w_retire_nxt = 1'b1;
            w_state_nxt  = S_FETCH;
          end
        end
      end

      S_WB: begin
        w_rf_we        = 1'b1;
        w_retire_nxt   = 1'b1;
        w_mem_req_nxt  = run;
        w_mem_we_nxt   = 1'b0;
        w_mem_addr_nxt = r_pc;
        w_state_nxt    = S_FETCH;
      end

      default: begin
        w_mem_req_nxt = 1'b0;
        w_mem_we_nxt  = 1'b0;
        w_state_nxt   = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc        <= c_reset_pc;
      r_ir        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_d         <= '0;
      r_res       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_retire    <= 1'b0;
      r_beq_taken <= 1'b0;
    end else begin
      r_pc        <= w_pc_nxt;
      r_ir        <= w_ir_nxt;
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_d         <= w_d_nxt;
      r_res       <= w_res_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_retire    <= w_retire_nxt;
      r_beq_taken <= w_beq_taken_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_rf_we && (w_rd != c_r0)) begin
      r_regs[w_rd] <= r_res;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_datapath_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_datapath_mc
// Description : Directed self-checking bench for cpu_datapath_mc.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_datapath_mc;

  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010,
                         OP_OR  = 3'b011, OP_ADDI = 3'b100, OP_LD = 3'b101,
                         OP_ST  = 3'b110, OP_BEQ = 3'b111;

  logic        clk;
  logic        reset;
  logic        run;
  logic        mem_req;
  logic        mem_we;
  logic [12:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic [12:0] pc;
  logic        retire;
  logic        beq_taken;
  logic [2:0]  dbg_sel;
  logic [15:0] dbg_data;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] mem [0:8191];
  int          wait_cycles = 0;
  bit          force_ack   = 1'b0;
  bit          gap_err     = 1'b0;
  logic [12:0] wr_addr     = '0;
  logic [15:0] wr_data     = '0;
  int          wr_len      = 0;

  cpu_datapath_mc #(
    .DATA_W(16), .ADDR_W(13), .REG_AW(3), .IMM_W(4), .RESET_PC(0)
  ) dut (
    .clk(clk), .reset(reset), .run(run),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .pc(pc), .retire(retire), .beq_taken(beq_taken),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs, input logic [2:0] rt,
                                      input logic [3:0] imm);
    return {op, rd, rs, rt, imm};
  endfunction

  // Memory acks after wait_cycles idle request cycles; writes land on the ack.
  task automatic responder();
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (mem_ack) begin
          gap_err   = 1'b1;
          mem_ack   = 1'b0;
          mem_rdata = 16'hDEAD;
          cnt       = 0;
        end else if (cnt >= wait_cycles) begin
          mem_ack   = 1'b1;
          mem_rdata = mem[mem_addr];
          if (mem_we) begin
            mem[mem_addr] = mem_wdata;
            wr_addr       = mem_addr;
            wr_data       = mem_wdata;
            wr_len        = cnt + 1;
          end
          cnt = 0;
        end else begin
          cnt++;
          mem_ack   = 1'b0;
          mem_rdata = 16'hDEAD;
        end
      end else begin
        cnt       = 0;
        mem_ack   = force_ack;
        mem_rdata = 16'hDEAD;
      end
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 8192; i++) mem[i] = 16'h0000;
  endtask

  task automatic start_core(input int wc);
    wait_cycles = wc;
    gap_err     = 1'b0;
    reset       = 1'b0;
    run         = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run   = 1'b1;
  endtask

  task automatic wait_fetch(input logic [12:0] a, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (mem_req && !mem_we && mem_addr == a) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic cycles_to_retire(output int n);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (retire) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit seen;
    reset = 1'b0; run = 1'b0; dbg_sel = '0;
    #12;
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b expected 0", mem_req); end
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b expected 0", mem_we); end
    vectors++; if (mem_addr !== 13'h0) begin miscompares++; $display("FAIL reset_addr: got %h expected 0", mem_addr); end
    vectors++; if (mem_wdata !== 16'h0) begin miscompares++; $display("FAIL reset_wdata: got %h expected 0", mem_wdata); end
    vectors++; if (pc !== 13'h0) begin miscompares++; $display("FAIL reset_pc: got %h expected 0", pc); end
    vectors++; if (retire !== 1'b0 || beq_taken !== 1'b0) begin miscompares++; $display("FAIL reset_pulses: got %b%b expected 00", retire, beq_taken); end
    for (int i = 0; i < 8; i++) begin
      dbg_sel = 3'(i);
      #1;
      vectors++; if (dbg_data !== 16'h0) begin miscompares++; $display("FAIL reset_reg%0d: got %h expected 0", i, dbg_data); end
    end
    @(negedge clk);
    reset = 1'b1;
    seen  = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (mem_req) seen = 1'b1;
    end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL idle_no_run: got req=1 expected 0"); end
  endtask

  task automatic test_addi_latency();
    bit ok; int n;
    clear_mem();
    mem[0] = enc(OP_ADDI, 3'd1, 3'd0, 3'd0, 4'd5);
    mem[1] = enc(OP_BEQ, 3'd0, 3'd0, 3'd0, 4'hF);
    start_core(0);
    wait_fetch(13'd0, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL first_fetch_addr0: got timeout expected fetch at 0"); end
    cycles_to_retire(n);
    vectors++; if (n !== 4) begin miscompares++; $display("FAIL addi_latency: got %0d expected 4", n); end
    vectors++; if (pc !== 13'd1) begin miscompares++; $display("FAIL addi_pc: got %h expected 1", pc); end
    dbg_sel = 3'd1; #1;
    vectors++; if (dbg_data !== 16'd5) begin miscompares++; $display("FAIL addi_r1: got %h expected 0005", dbg_data); end
  endtask

  task automatic test_alu();
    logic [15:0] exp [8];
    clear_mem();
    mem[0] = enc(OP_ADDI, 3'd1, 3'd0, 3'd0, 4'd7);
    mem[1] = enc(OP_ADDI, 3'd2, 3'd0, 3'd0, 4'hE);
    mem[2] = enc(OP_SUB,  3'd3, 3'd1, 3'd2, 4'd0);
    mem[3] = enc(OP_ADD,  3'd0, 3'd1, 3'd1, 4'd0);
    mem[4] = enc(OP_AND,  3'd5, 3'd1, 3'd2, 4'd0);
    mem[5] = enc(OP_OR,   3'd6, 3'd1, 3'd2, 4'd0);
    mem[6] = enc(OP_BEQ,  3'd0, 3'd0, 3'd0, 4'hF);
    exp[0] = 16'h0000; exp[1] = 16'h0007; exp[2] = 16'hFFFE; exp[3] = 16'h0009;
    exp[4] = 16'h0000; exp[5] = 16'h0006; exp[6] = 16'hFFFF; exp[7] = 16'h0000;
    start_core(0);
    repeat (60) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      dbg_sel = 3'(i); #1;
      vectors++; if (dbg_data !== exp[i]) begin miscompares++; $display("FAIL alu_r%0d: got %h expected %h", i, dbg_data, exp[i]); end
    end
  endtask

  task automatic test_mem();
    bit ok; int n;
    clear_mem();
    mem[0]  = enc(OP_BEQ,  3'd0, 3'd0, 3'd0, 4'd7);
    mem[8]  = enc(OP_ADDI, 3'd1, 3'd0, 3'd0, 4'd7);
    mem[9]  = enc(OP_ST,   3'd1, 3'd0, 3'd0, 4'd3);
    mem[10] = enc(OP_LD,   3'd4, 3'd0, 3'd0, 4'd3);
    mem[11] = enc(OP_BEQ,  3'd0, 3'd0, 3'd0, 4'hF);
    start_core(2);
    wait_fetch(13'd9, ok);
    cycles_to_retire(n);
    vectors++; if (ok !== 1'b1 || n !== 8) begin miscompares++; $display("FAIL st_latency: got %0d (fetch seen %b) expected 8", n, ok); end
    wait_fetch(13'd10, ok);
    cycles_to_retire(n);
    vectors++; if (ok !== 1'b1 || n !== 9) begin miscompares++; $display("FAIL ld_latency: got %0d (fetch seen %b) expected 9", n, ok); end
    vectors++; if (wr_addr !== 13'd3 || wr_data !== 16'd7) begin miscompares++; $display("FAIL st_write: got addr %h data %h expected 0003/0007", wr_addr, wr_data); end
    vectors++; if (wr_len !== 3) begin miscompares++; $display("FAIL st_req_hold: got %0d expected 3", wr_len); end
    vectors++; if (mem[3] !== 16'd7) begin miscompares++; $display("FAIL mem3: got %h expected 0007", mem[3]); end
    dbg_sel = 3'd4; #1;
    vectors++; if (dbg_data !== 16'd7) begin miscompares++; $display("FAIL ld_r4: got %h expected 0007", dbg_data); end
    vectors++; if (gap_err !== 1'b0) begin miscompares++; $display("FAIL req_gap: got back-to-back req expected idle gap"); end
  endtask

  task automatic test_beq();
    bit ok; int n;
    clear_mem();
    mem[0]  = enc(OP_ADDI, 3'd1, 3'd0, 3'd0, 4'd7);
    mem[1]  = enc(OP_ADDI, 3'd2, 3'd0, 3'd0, 4'd3);
    mem[2]  = enc(OP_BEQ,  3'd0, 3'd0, 3'd0, 4'd7);
    mem[10] = enc(OP_BEQ,  3'd1, 3'd1, 3'd0, 4'hD);
    mem[8]  = enc(OP_BEQ,  3'd0, 3'd0, 3'd0, 4'hF);
    start_core(0);
    wait_fetch(13'd10, ok);
    cycles_to_retire(n);
    vectors++; if (ok !== 1'b1 || n !== 3) begin miscompares++; $display("FAIL beq_latency: got %0d (fetch seen %b) expected 3", n, ok); end
    vectors++; if (beq_taken !== 1'b1) begin miscompares++; $display("FAIL beq_taken_pulse: got %b expected 1", beq_taken); end
    vectors++; if (pc !== 13'd8) begin miscompares++; $display("FAIL beq_target: got %h expected 0008", pc); end
    @(negedge clk);
    vectors++; if (beq_taken !== 1'b0) begin miscompares++; $display("FAIL beq_one_cycle: got %b expected 0", beq_taken); end

    mem[10] = enc(OP_BEQ, 3'd1, 3'd2, 3'd0, 4'hD);
    mem[11] = enc(OP_BEQ, 3'd0, 3'd0, 3'd0, 4'hF);
    start_core(0);
    wait_fetch(13'd10, ok);
    cycles_to_retire(n);
    vectors++; if (ok !== 1'b1 || n !== 3) begin miscompares++; $display("FAIL beq_nt_latency: got %0d (fetch seen %b) expected 3", n, ok); end
    vectors++; if (beq_taken !== 1'b0) begin miscompares++; $display("FAIL beq_not_taken: got %b expected 0", beq_taken); end
    vectors++; if (pc !== 13'd11) begin miscompares++; $display("FAIL beq_fallthrough: got %h expected 000b", pc); end
  endtask

  task automatic test_wrap();
    bit ok; int n;
    clear_mem();
    mem[0]    = enc(OP_BEQ,  3'd1, 3'd0, 3'd0, 4'hE);
    mem[8191] = enc(OP_ADDI, 3'd1, 3'd0, 3'd0, 4'hF);
    mem[1]    = enc(OP_ADD,  3'd1, 3'd1, 3'd1, 4'd0);
    mem[2]    = enc(OP_BEQ,  3'd0, 3'd0, 3'd0, 4'hF);
    start_core(0);
    wait_fetch(13'd8191, ok);
    vectors++; if (ok !== 1'b1 || pc !== 13'h1FFF) begin miscompares++; $display("FAIL wrap_fetch_top: got pc %h (fetch seen %b) expected 1fff", pc, ok); end
    cycles_to_retire(n);
    vectors++; if (n !== 4 || pc !== 13'h0) begin miscompares++; $display("FAIL wrap_pc: got pc %h after %0d cycles expected 0000 after 4", pc, n); end
    repeat (40) @(negedge clk);
    dbg_sel = 3'd1; #1;
    vectors++; if (dbg_data !== 16'hFFFE) begin miscompares++; $display("FAIL wrap_r1: got %h expected fffe", dbg_data); end
  endtask

  task automatic test_reset_mid();
    bit ok; bit bad;
    clear_mem();
    mem[0] = enc(OP_ADDI, 3'd1, 3'd0, 3'd0, 4'd5);
    mem[1] = enc(OP_LD,   3'd2, 3'd0, 3'd0, 4'd4);
    mem[2] = enc(OP_BEQ,  3'd0, 3'd0, 3'd0, 4'hF);
    mem[4] = 16'h1234;
    start_core(6);
    wait_fetch(13'd4, ok);
    repeat (2) @(negedge clk);
    dbg_sel = 3'd1; #1;
    vectors++; if (ok !== 1'b1 || mem_req !== 1'b1 || dbg_data !== 16'd5) begin miscompares++; $display("FAIL mid_setup: got req %b r1 %h (seen %b) expected 1/0005", mem_req, dbg_data, ok); end
    #1;
    reset = 1'b0;
    run   = 1'b0;
    #1;
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL mid_req_drop: got %b expected 0", mem_req); end
    vectors++; if (pc !== 13'h0 || mem_addr !== 13'h0) begin miscompares++; $display("FAIL mid_pc: got pc %h addr %h expected 0000", pc, mem_addr); end
    vectors++; if (dbg_data !== 16'h0) begin miscompares++; $display("FAIL mid_r1_clear: got %h expected 0000", dbg_data); end
    @(negedge clk);
    reset     = 1'b1;
    force_ack = 1'b1;
    bad       = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (mem_req !== 1'b0 || pc !== 13'h0 || retire !== 1'b0) bad = 1'b1;
    end
    force_ack = 1'b0;
    vectors++; if (bad !== 1'b0) begin miscompares++; $display("FAIL stray_ack: got activity with run=0 expected idle, pc %h", pc); end
  endtask

  initial begin
    reset     = 1'b0;
    run       = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
    dbg_sel   = '0;
    fork
      responder();
    join_none
    test_reset();
    test_addi_latency();
    test_alu();
    test_mem();
    test_beq();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
